// File: rtl/qec_syndrome_filter_decoder.sv
// qec_syndrome_filter_decoder
// Three-stage syndrome pipeline: input register, per-axis repetition filter,
// then a lookup-table decode into a one-hot correction.
// Emitted corrections are folded into X/Z Pauli frames.
module qec_syndrome_filter_decoder #(
  parameter int NQ     = 5,
  parameter int NS     = 4,
  parameter int ROUNDS = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          syn_valid,
  input  logic [1:0]    syn_axis,
  input  logic [NS-1:0] syn,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_axis,
  input  logic [NS-1:0] cfg_addr,
  input  logic [NQ-1:0] cfg_data,
  input  logic          frame_clr,
  output logic          corr_valid,
  output logic [NQ-1:0] corr,
  output logic [1:0]    corr_axis,
  output logic          corr_unk,
  output logic [NQ-1:0] frame_x,
  output logic [NQ-1:0] frame_z
);

  localparam int CW    = $clog2(ROUNDS + 1);
  localparam int DEPTH = 1 << NS;

  // Stage 0: registered sample; axis-00 samples are dropped here.
  logic          s0_valid_q;
  logic [1:0]    s0_axis_q;
  logic [NS-1:0] s0_syn_q;

  // Stage 1: accepted, nonzero syndrome awaiting decode.
  logic          s1_emit_q;
  logic [1:0]    s1_axis_q;
  logic [NS-1:0] s1_syn_q;

  // Stage 2: output and frame registers.
  logic          corr_valid_q;
  logic [NQ-1:0] corr_q;
  logic [1:0]    corr_axis_q;
  logic          corr_unk_q;
  logic [NQ-1:0] frame_x_q, frame_x_d;
  logic [NQ-1:0] frame_z_q, frame_z_d;

  logic [2:0]          acc_ax;
  logic [2:0][NQ-1:0]  bank_rd;
  logic [NQ-1:0]       entry;

  // Input sample register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_valid_q <= 1'b0;
      s0_axis_q  <= '0;
      s0_syn_q   <= '0;
    end else begin
      s0_valid_q <= syn_valid && (syn_axis != 2'b00);
      s0_axis_q  <= syn_axis;
      s0_syn_q   <= syn;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic [NS-1:0] last_q;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          hit;
      logic          same;
      logic [NQ-1:0] mem_q [DEPTH];

      assign hit  = s0_valid_q && (s0_axis_q == 2'(gi + 1));
      assign same = (s0_syn_q == last_q);
      // A repeated value counts up and saturates; a new value restarts at one.
      assign cnt_d = same ? ((cnt_q == CW'(ROUNDS)) ? cnt_q : cnt_q + CW'(1))
                          : CW'(1);
      // Accept only on the transition into ROUNDS, never while saturated.
      assign acc_ax[gi] = hit && (cnt_d == CW'(ROUNDS)) &&
                          !(same && (cnt_q == CW'(ROUNDS)));

      // Per-axis repetition filter state.
      always_ff @(posedge CLK) begin
        if (RST) begin
          last_q <= '0;
          cnt_q  <= '0;
        end else if (hit) begin
          last_q <= s0_syn_q;
          cnt_q  <= cnt_d;
        end
      end

      // Per-axis correction table; a same-cycle lookup sees the old entry.
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (cfg_we && (cfg_axis == 2'(gi + 1))) begin
          mem_q[cfg_addr] <= cfg_data;
        end
      end

      assign bank_rd[gi] = mem_q[s1_syn_q];
    end
  endgenerate

  // Filter-stage register: forward only accepted nonzero syndromes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_emit_q <= 1'b0;
      s1_axis_q <= '0;
      s1_syn_q  <= '0;
    end else begin
      s1_emit_q <= (|acc_ax) && (s0_syn_q != '0);
      s1_axis_q <= s0_axis_q;
      s1_syn_q  <= s0_syn_q;
    end
  end

  // Select the bank addressed by the stage-1 axis and fold it into the frames.
  always_comb begin
    entry     = bank_rd[2];
    frame_x_d = frame_x_q;
    frame_z_d = frame_z_q;
    if (s1_axis_q == 2'b01)      entry = bank_rd[0];
    else if (s1_axis_q == 2'b10) entry = bank_rd[1];
    if (s1_emit_q && (entry != '0)) begin
      if (s1_axis_q != 2'b11) frame_x_d = frame_x_q ^ entry;
      if (s1_axis_q != 2'b01) frame_z_d = frame_z_q ^ entry;
    end
    if (frame_clr) begin
      frame_x_d = '0;
      frame_z_d = '0;
    end
  end

  // Output register; correction fields hold between pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      corr_valid_q <= 1'b0;
      corr_q       <= '0;
      corr_axis_q  <= '0;
      corr_unk_q   <= 1'b0;
      frame_x_q    <= '0;
      frame_z_q    <= '0;
    end else begin
      corr_valid_q <= s1_emit_q;
      if (s1_emit_q) begin
        corr_q      <= entry;
        corr_axis_q <= s1_axis_q;
        corr_unk_q  <= (entry == '0);
      end
      frame_x_q <= frame_x_d;
      frame_z_q <= frame_z_d;
    end
  end

  assign corr_valid = corr_valid_q;
  assign corr       = corr_q;
  assign corr_axis  = corr_axis_q;
  assign corr_unk   = corr_unk_q;
  assign frame_x    = frame_x_q;
  assign frame_z    = frame_z_q;

endmodule
